// File: rtl/a2600_ce_gen.sv
// a2600_ce_gen: Atari 2600 clock-enable generator for the 57.5 MHz PLL domain.
// A fractional phase accumulator produces the colour-clock enable (NTSC or PAL
// rate). A divide-by-3 on its carries produces the CPU enable. A small lock
// sequencer holds the rest of the core in reset until the PLL has stayed locked
// long enough.
// Optional feature macro: A2600_CE_LOCKSTAT_EN adds the saturating lock_loss
// counter and its port.
module a2600_ce_gen #(
  parameter int unsigned      ACC_W     = 32,
  parameter logic [ACC_W-1:0] INC_NTSC  = 267374412,
  parameter logic [ACC_W-1:0] INC_PAL   = 264935543,
  parameter int unsigned      LOCK_HOLD = 1024
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       pll_locked,
  input  logic       pal,
  input  logic       pause,
  output logic       ce_color,
  output logic       ce_cpu,
  output logic       core_reset
`ifdef A2600_CE_LOCKSTAT_EN
  ,
  output logic [7:0] lock_loss
`endif
);

  localparam int unsigned HOLD_W = (LOCK_HOLD > 1) ? $clog2(LOCK_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LOCK_HOLD - 1);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    HOLD      = 2'd1,
    RUN       = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_nextState;
  logic [HOLD_W-1:0] r_holdCnt;
  logic [HOLD_W-1:0] w_nextHoldCnt;

  logic [ACC_W-1:0]  r_acc;
  logic [1:0]        r_div3;
  logic              r_ceColor;
  logic              r_ceCpu;
  logic [ACC_W-1:0]  w_inc;
  logic [ACC_W:0]    w_sum;
  logic              w_keepRun;

  // Lock sequencer state register; reset always returns to waiting for lock.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_state   <= WAIT_LOCK;
      r_holdCnt <= '0;
    end else begin
      r_state   <= w_nextState;
      r_holdCnt <= w_nextHoldCnt;
    end
  end

  // Lock sequencer next state: any lock drop restarts the full hold period.
  always_comb begin
    w_nextState   = r_state;
    w_nextHoldCnt = r_holdCnt;
    core_reset    = 1'b1;
    case (r_state)
      WAIT_LOCK: begin
        if (pll_locked) begin
          w_nextState   = HOLD;
          w_nextHoldCnt = '0;
        end
      end
      HOLD: begin
        if (!pll_locked) begin
          w_nextState   = WAIT_LOCK;
          w_nextHoldCnt = '0;
        end else if (r_holdCnt == HOLD_LAST) begin
          w_nextState   = RUN;
          w_nextHoldCnt = '0;
        end else begin
          w_nextHoldCnt = r_holdCnt + 1'b1;
        end
      end
      RUN: begin
        core_reset = 1'b0;
        if (!pll_locked) begin
          w_nextState = WAIT_LOCK;
        end
      end
      default: begin
        w_nextState   = WAIT_LOCK;
        w_nextHoldCnt = '0;
      end
    endcase
  end

  // The enables only advance while RUN will still hold after this edge. A lock
  // drop therefore never emits a pulse alongside the re-asserted core_reset.
  assign w_keepRun = (r_state == RUN) && pll_locked;
  assign w_inc     = pal ? INC_PAL : INC_NTSC;
  assign w_sum     = {1'b0, r_acc} + {1'b0, w_inc};

  // Phase accumulator and divide-by-3. The carry out of the add is the colour
  // enable. Leaving RUN zeroes the phase so the next RUN restarts cleanly.
  always_ff @(posedge clk_sys) begin
    if (reset || !w_keepRun) begin
      r_acc     <= '0;
      r_div3    <= 2'd0;
      r_ceColor <= 1'b0;
      r_ceCpu   <= 1'b0;
    end else if (pause) begin
      r_ceColor <= 1'b0;
      r_ceCpu   <= 1'b0;
    end else begin
      r_acc     <= w_sum[ACC_W-1:0];
      r_ceColor <= w_sum[ACC_W];
      r_ceCpu   <= 1'b0;
      if (w_sum[ACC_W]) begin
        if (r_div3 == 2'd2) begin
          r_div3  <= 2'd0;
          r_ceCpu <= 1'b1;
        end else begin
          r_div3  <= r_div3 + 2'd1;
        end
      end
    end
  end

  assign ce_color = r_ceColor;
  assign ce_cpu   = r_ceCpu;

`ifdef A2600_CE_LOCKSTAT_EN
  logic [7:0] r_lockLoss;
  logic       w_lockDrop;

  assign w_lockDrop = (r_state == RUN) && !pll_locked;

  // Counts lock losses seen while running. It saturates and is cleared only by reset.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_lockLoss <= 8'd0;
    end else if (w_lockDrop && (r_lockLoss != 8'hFF)) begin
      r_lockLoss <= r_lockLoss + 8'd1;
    end
  end

  assign lock_loss = r_lockLoss;
`endif

endmodule

// File: tb/tb_a2600_ce_gen.sv
// tb_a2600_ce_gen: directed test of a2600_ce_gen.
// u_dut uses small parameters (8-bit accumulator, LOCK_HOLD=4) so that pulse
// positions can be worked out by hand. u_dflt uses the default parameters and
// checks the NTSC rate and its gap pattern.
module tb_a2600_ce_gen;

  logic clk;
  logic reset;
  logic pllLocked;
  logic pal;
  logic pause;
  logic ceColor;
  logic ceCpu;
  logic coreReset;

  logic reset2;
  logic locked2;
  logic pal2;
  logic pause2;
  logic ceColor2;
  logic ceCpu2;
  logic coreReset2;

`ifdef A2600_CE_LOCKSTAT_EN
  logic [7:0] lockLoss;
  logic [7:0] lockLoss2;
`endif

  int total;
  int bad;

  a2600_ce_gen #(
    .ACC_W    (8),
    .INC_NTSC (8'd64),
    .INC_PAL  (8'd128),
    .LOCK_HOLD(4)
  ) u_dut (
    .clk_sys   (clk),
    .reset     (reset),
    .pll_locked(pllLocked),
    .pal       (pal),
    .pause     (pause),
    .ce_color  (ceColor),
    .ce_cpu    (ceCpu),
    .core_reset(coreReset)
`ifdef A2600_CE_LOCKSTAT_EN
    ,
    .lock_loss (lockLoss)
`endif
  );

  a2600_ce_gen u_dflt (
    .clk_sys   (clk),
    .reset     (reset2),
    .pll_locked(locked2),
    .pal       (pal2),
    .pause     (pause2),
    .ce_color  (ceColor2),
    .ce_cpu    (ceCpu2),
    .core_reset(coreReset2)
`ifdef A2600_CE_LOCKSTAT_EN
    ,
    .lock_loss (lockLoss2)
`endif
  );

  // Free-running system clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, then settle so outputs are sampled away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset state, then release with lock held: core_reset stays high after edges
  // 1..4 (WAIT_LOCK plus HOLD counts 0..2) and drops after edge 5.
  task automatic test_reset();
    reset = 1'b1; pllLocked = 1'b1; pal = 1'b0; pause = 1'b0;
    tick(); tick();
    total++;
    if (coreReset !== 1'b1 || ceColor !== 1'b0 || ceCpu !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_state: got cr=%b cc=%b cpu=%b need 1 0 0", coreReset, ceColor, ceCpu);
    end
`ifdef A2600_CE_LOCKSTAT_EN
    total++;
    if (lockLoss !== 8'd0) begin
      bad++;
      $display("[TB] FAIL reset_lockloss: got %0d need 0", lockLoss);
    end
`endif
    reset = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      total++;
      if (coreReset !== (k < 5) || ceColor !== 1'b0 || ceCpu !== 1'b0) begin
        bad++;
        $display("[TB] FAIL lock_seq k=%0d: got cr=%b cc=%b cpu=%b need cr=%b 0 0", k, coreReset, ceColor, ceCpu, (k < 5));
      end
    end
  endtask

  // NTSC increment 64 gives a carry every 4th edge and a CPU enable every 12th.
  task automatic test_ntsc_rate();
    logic expC, expP;
    for (int j = 1; j <= 24; j++) begin
      tick();
      expC = (j % 4 == 0);
      expP = (j % 12 == 0);
      total++;
      if (ceColor !== expC || ceCpu !== expP) begin
        bad++;
        $display("[TB] FAIL ntsc_rate j=%0d: got cc=%b cpu=%b need %b %b", j, ceColor, ceCpu, expC, expP);
      end
    end
  endtask

  // The accumulator is at 0 and div3 at 0. PAL increment 128 gives a carry every
  // 2nd edge. The third carry (t=6) is the CPU enable.
  task automatic test_pal_switch();
    logic expC, expP;
    pal = 1'b1;
    for (int t = 1; t <= 8; t++) begin
      tick();
      expC = (t % 2 == 0);
      expP = (t == 6);
      total++;
      if (ceColor !== expC || ceCpu !== expP) begin
        bad++;
        $display("[TB] FAIL pal_switch t=%0d: got cc=%b cpu=%b need %b %b", t, ceColor, ceCpu, expC, expP);
      end
    end
    pal = 1'b0;
  endtask

  // The test starts with acc=0 and div3=1. After two NTSC steps acc=128. The
  // pause freezes acc and div3. After release, carries land at t=2 (div3 becomes
  // 2) and at t=6 (the CPU enable).
  task automatic test_pause();
    logic expC, expP;
    tick(); tick();
    pause = 1'b1;
    for (int t = 1; t <= 50; t++) begin
      tick();
      total++;
      if (ceColor !== 1'b0 || ceCpu !== 1'b0) begin
        bad++;
        $display("[TB] FAIL pause_quiet t=%0d: got cc=%b cpu=%b need 0 0", t, ceColor, ceCpu);
      end
    end
    pause = 1'b0;
    for (int t = 1; t <= 6; t++) begin
      tick();
      expC = (t == 2) || (t == 6);
      expP = (t == 6);
      total++;
      if (ceColor !== expC || ceCpu !== expP) begin
        bad++;
        $display("[TB] FAIL pause_resume t=%0d: got cc=%b cpu=%b need %b %b", t, ceColor, ceCpu, expC, expP);
      end
    end
  endtask

  // A one-clock lock drop in RUN raises core_reset and stops the enables. The
  // relock repeats the full hold. The phase then restarts from 0, so the first
  // colour enable comes 4 edges later with no CPU enable.
  task automatic test_lock_loss();
    logic expC;
    pllLocked = 1'b0;
    tick();
    total++;
    if (coreReset !== 1'b1 || ceColor !== 1'b0 || ceCpu !== 1'b0) begin
      bad++;
      $display("[TB] FAIL lock_drop: got cr=%b cc=%b cpu=%b need 1 0 0", coreReset, ceColor, ceCpu);
    end
`ifdef A2600_CE_LOCKSTAT_EN
    total++;
    if (lockLoss !== 8'd1) begin
      bad++;
      $display("[TB] FAIL lockloss_count: got %0d need 1", lockLoss);
    end
`endif
    pllLocked = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      total++;
      if (coreReset !== (k < 5) || ceColor !== 1'b0) begin
        bad++;
        $display("[TB] FAIL relock k=%0d: got cr=%b cc=%b need cr=%b cc=0", k, coreReset, ceColor, (k < 5));
      end
    end
    for (int j = 1; j <= 4; j++) begin
      tick();
      expC = (j == 4);
      total++;
      if (ceColor !== expC || ceCpu !== 1'b0) begin
        bad++;
        $display("[TB] FAIL restart_phase j=%0d: got cc=%b cpu=%b need %b 0", j, ceColor, ceCpu, expC);
      end
    end
  endtask

  // Reset asserted mid-run takes effect on the next edge.
  task automatic test_reset_midrun();
    tick(); tick();
    reset = 1'b1;
    tick();
    total++;
    if (coreReset !== 1'b1 || ceColor !== 1'b0 || ceCpu !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_midrun: got cr=%b cc=%b cpu=%b need 1 0 0", coreReset, ceColor, ceCpu);
    end
`ifdef A2600_CE_LOCKSTAT_EN
    total++;
    if (lockLoss !== 8'd0) begin
      bad++;
      $display("[TB] FAIL reset_midrun_lockloss: got %0d need 0", lockLoss);
    end
`endif
    reset = 1'b0;
  endtask

  // Default parameters: release comes 1025 edges after reset. From acc=0,
  // 20000 NTSC steps give floor(20000*267374412/2^32) = 1245 carries. Every
  // gap between carries must be 16 or 17 clocks.
  task automatic test_default_rate();
    int waited;
    int count;
    int lastIdx;
    waited = 0;
    count = 0;
    lastIdx = 0;
    reset2 = 1'b1;
    tick();
    reset2 = 1'b0;
    while (coreReset2 === 1'b1 && waited < 2000) begin
      tick();
      waited++;
    end
    total++;
    if (waited !== 1025) begin
      bad++;
      $display("[TB] FAIL dflt_release: got %0d edges need 1025", waited);
    end
    for (int i = 1; i <= 20000; i++) begin
      tick();
      if (ceColor2 === 1'b1) begin
        if (lastIdx > 0) begin
          total++;
          if ((i - lastIdx) != 16 && (i - lastIdx) != 17) begin
            bad++;
            $display("[TB] FAIL dflt_gap at %0d: got %0d need 16 or 17", i, i - lastIdx);
          end
        end
        lastIdx = i;
        count++;
      end
    end
    total++;
    if (count !== 1245) begin
      bad++;
      $display("[TB] FAIL dflt_count: got %0d need 1245", count);
    end
  endtask

  // Test sequence.
  initial begin
    total = 0;
    bad = 0;
    reset = 1'b1; pllLocked = 1'b0; pal = 1'b0; pause = 1'b0;
    reset2 = 1'b1; locked2 = 1'b1; pal2 = 1'b0; pause2 = 1'b0;
    test_reset();
    test_ntsc_rate();
    test_pal_switch();
    test_pause();
    test_lock_loss();
    test_reset_midrun();
    test_default_rate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
